imem_flash_loader: RTL

// - Boot loader between the UART byte receiver and the instruction memory write port.
// - While `flash` is high it holds the core, takes a length header and then little-endian

---
 rtl/imem_flash_loader.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/imem_flash_loader.sv
// UART-to-instruction-memory boot loader: length header, little-endian words, bounds/abort checks.
// Optional trailing XOR checksum byte is compiled in with `define LOADER_CHECKSUM_EN.
module imem_flash_loader #(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 256,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int LEN_BYTES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flash,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic              core_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int BPW     = XLEN / 8;
  localparam int LEN_W   = 8 * LEN_BYTES;
  localparam int CNT_W   = (LEN_W > ADDR_W + 1) ? LEN_W : ADDR_W + 1;
  localparam int IDX_MAX = (BPW > LEN_BYTES) ? BPW : LEN_BYTES;
  localparam int IDX_W   = $clog2(IDX_MAX) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
`ifdef LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t           state, state_nx;
  logic [LEN_W-1:0] wcount, len_now;
  logic [XLEN-1:0]  word, word_now;
  logic [IDX_W-1:0] byte_idx;
  logic             start, len_byte, data_byte, word_done, go_done, go_err;
  logic             last_hdr, last_byte, final_wr, too_big;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]       csum;
  logic             cks_ok;

  assign cks_ok = (rx_data == csum);
`endif

  assign last_hdr  = (byte_idx == IDX_W'(LEN_BYTES - 1));
  assign last_byte = (byte_idx == IDX_W'(BPW - 1));
  assign too_big   = (CNT_W'(len_now) > CNT_W'(DEPTH));
  // The write cycle of the last word is the cue to leave DATA.
  assign final_wr  = (state == S_DATA) && mem_we &&
                     (CNT_W'(words_loaded) == CNT_W'(wcount));
  assign word_done = data_byte && last_byte;

`ifdef LOADER_CHECKSUM_EN
  assign busy = (state == S_LEN) || (state == S_DATA) || (state == S_CHK);
`else
  assign busy = (state == S_LEN) || (state == S_DATA);
`endif
  assign core_hold = busy;

  always_comb begin
    len_now = wcount;
    len_now[8*byte_idx +: 8] = rx_data;
    word_now = word;
    word_now[8*byte_idx +: 8] = rx_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    start     = 1'b0;
    len_byte  = 1'b0;
    data_byte = 1'b0;
    go_done   = 1'b0;
    go_err    = 1'b0;
    case (state)
      S_IDLE: begin
        if (flash) begin
          state_nx = S_LEN;
          start    = 1'b1;
        end
      end
      S_LEN: begin
        if (!flash) begin
          state_nx = S_IDLE;
          go_err   = 1'b1;
        end else if (rx_valid) begin
          len_byte = 1'b1;
          if (last_hdr) begin
            if (len_now == '0) begin
              state_nx = S_DONE;
              go_done  = 1'b1;
            end else if (too_big) begin
              state_nx = S_ERR;
              go_err   = 1'b1;
            end else begin
              state_nx = S_DATA;
            end
          end
        end
      end
      S_DATA: begin
        if (!flash) begin
          state_nx = S_IDLE;
          go_err   = 1'b1;
        end else if (final_wr) begin
`ifdef LOADER_CHECKSUM_EN
          // A checksum byte may already arrive in the final write cycle.
          if (rx_valid) begin
            state_nx = cks_ok ? S_DONE : S_ERR;
            go_done  = cks_ok;
            go_err   = !cks_ok;
          end else begin
            state_nx = S_CHK;
          end
`else
          state_nx = S_DONE;
          go_done  = 1'b1;
`endif
        end else if (rx_valid) begin
          data_byte = 1'b1;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (!flash) begin
          state_nx = S_IDLE;
          go_err   = 1'b1;
        end else if (rx_valid) begin
          state_nx = cks_ok ? S_DONE : S_ERR;
          go_done  = cks_ok;
          go_err   = !cks_ok;
        end
      end
`endif
      S_DONE, S_ERR: begin
        if (!flash) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      words_loaded <= '0;
      wcount       <= '0;
      byte_idx     <= '0;
      done         <= 1'b0;
      error        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      mem_we <= word_done;
      if (start) begin
        words_loaded <= '0;
        wcount       <= '0;
        byte_idx     <= '0;
        done         <= 1'b0;
        error        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
        csum         <= '0;
`endif
      end
      if (len_byte) begin
        wcount   <= len_now;
        byte_idx <= last_hdr ? '0 : byte_idx + 1'b1;
      end
      if (data_byte) begin
`ifdef LOADER_CHECKSUM_EN
        csum <= csum ^ rx_data;
`endif
        if (last_byte) begin
          mem_addr     <= words_loaded[ADDR_W-1:0];
          mem_wdata    <= word_now;
          words_loaded <= words_loaded + 1'b1;
          byte_idx     <= '0;
        end else begin
          byte_idx <= byte_idx + 1'b1;
        end
      end
      if (go_done) done  <= 1'b1;
      if (go_err)  error <= 1'b1;
    end
  end

  // Word assembly buffer; every byte is overwritten before the word is used.
  always_ff @(posedge clk) begin
    if (data_byte) word <= word_now;
  end

endmodule
